// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: command codes,
// transaction states and status register bit positions.
package spi_flash_pkg;

  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_CE   = 8'hC7;
  // Not a real opcode; marks "no command pending an end-of-transaction action".
  localparam logic [7:0] CMD_NONE = 8'h00;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_OUT,
    ST_PP_IN,
    ST_IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s         = '0;
    s[SR_WEL] = wel;
    s[SR_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a flash master and the responder.
interface spi_flash_responder_if;
  logic csn;
  logic sck;
  logic sdi_dq0;
  logic sdo_dq1;
  logic wpn_dq2;
  logic hldn_dq3;
  logic busy;

  modport master (
    output csn, sck, sdi_dq0, wpn_dq2, hldn_dq3,
    input  sdo_dq1, busy
  );

  modport slave (
    input  csn, sck, sdi_dq0, wpn_dq2, hldn_dq3,
    output sdo_dq1, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer followed by one delay stage for rise/fall pulse detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] sh_q;

  // shift the asynchronous input through the sync chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= {3{RST_VAL}};
    else     sh_q <= {sh_q[1:0], d_i};
  end

  assign q_o    = sh_q[1];
  assign rise_o =  sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder: decodes RDID/RDSR/READ/PP/WREN/WRDI/CE on an
// oversampled mode-0 SPI bus and serves an internal byte memory.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_responder_if.slave  bus
);

  localparam int             AW   = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0]  ONE  = AW'(1);
  localparam logic [AW-1:0]  LAST = AW'(MEM_DEPTH - 1);

  // ---------------- input conditioning ----------------
  logic sck_rise_raw, sck_fall_raw, unused_sck_lvl;
  logic csn_s, csn_rise, csn_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d_i(bus.sck),
    .q_o(unused_sck_lvl), .rise_o(sck_rise_raw), .fall_o(sck_fall_raw)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .d_i(bus.csn),
    .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  // bit order {hldn, wpn, sdi}; sdi stays aligned with the synchronized sck
  logic [2:0] psync1_q, psync2_q;

  // plain 2-FF synchronizers for the level inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psync1_q <= 3'b110;
      psync2_q <= 3'b110;
    end else begin
      psync1_q <= {bus.hldn_dq3, bus.wpn_dq2, bus.sdi_dq0};
      psync2_q <= psync1_q;
    end
  end

  logic sdi_s, wpn_s, hld_s;
  assign sdi_s = psync2_q[0];
  assign wpn_s = psync2_q[1];
  assign hld_s = psync2_q[2];

  // csn edges take precedence; hold freezes the sck edge stream
  logic sck_ok, sck_rise, sck_fall;
  assign sck_ok   = hld_s & ~csn_s & ~csn_rise & ~csn_fall;
  assign sck_rise = sck_rise_raw & sck_ok;
  assign sck_fall = sck_fall_raw & sck_ok;

  // ---------------- state ----------------
  state_e        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [22:0]   addr_q, addr_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    tx_q, tx_d;
  logic [2:0]    out_cnt_q, out_cnt_d;
  logic [1:0]    id_idx_q, id_idx_d;
  logic          wel_q, wel_d;
  logic          wip_q, wip_d;
  logic [AW-1:0] er_ptr_q, er_ptr_d;
  logic          sdo_q, sdo_d;

  logic [7:0]    mem [MEM_DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;

  logic [7:0]    byte_in;
  logic [23:0]   addr_in;
  logic [AW-1:0] a_lo;

  assign byte_in = {sh_q, sdi_s};
  assign addr_in = {addr_q, sdi_s};
  assign a_lo    = addr_in[AW-1:0];

  // next-state: erase engine, csn framing, rise-side decode, fall-side output
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    out_cnt_d = out_cnt_q;
    id_idx_d  = id_idx_q;
    wel_d     = wel_q;
    wip_d     = wip_q;
    er_ptr_d  = er_ptr_q;
    sdo_d     = sdo_q;
    mem_we    = 1'b0;
    mem_wa    = er_ptr_q;
    mem_wd    = 8'hFF;

    // erase owns the write port while WIP is set
    if (wip_q) begin
      mem_we   = 1'b1;
      er_ptr_d = er_ptr_q + ONE;
      if (er_ptr_q == LAST) wip_d = 1'b0;
    end

    if (csn_rise) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b0;
      cmd_d   = CMD_NONE;
      case (cmd_q)
        CMD_WREN: wel_d = 1'b1;
        CMD_WRDI: wel_d = 1'b0;
        CMD_PP:   wel_d = 1'b0;
        CMD_CE: begin
          wel_d = 1'b0;
          if (wel_q && wpn_s) begin
            wip_d    = 1'b1;
            er_ptr_d = '0;
          end
        end
        default: ;
      endcase
    end else if (csn_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      cmd_d     = CMD_NONE;
      sdo_d     = 1'b0;
    end else if (sck_rise) begin
      case (state_q)
        ST_CMD: begin
          sh_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            out_cnt_d = '0;
            state_d   = ST_IGNORE;
            if (!wip_q || byte_in == CMD_RDSR) begin
              case (byte_in)
                CMD_RDID: begin
                  state_d  = ST_RD_OUT;
                  cmd_d    = byte_in;
                  tx_d     = JEDEC_ID[23:16];
                  id_idx_d = 2'd1;
                end
                CMD_RDSR: begin
                  state_d = ST_RD_OUT;
                  cmd_d   = byte_in;
                  tx_d    = status_byte(wel_q, wip_q);
                end
                CMD_READ, CMD_PP: begin
                  state_d = ST_ADDR;
                  cmd_d   = byte_in;
                end
                // acted on at csn rise; remaining bits are don't-care
                CMD_WREN, CMD_WRDI, CMD_CE: cmd_d = byte_in;
                default: ;
              endcase
            end
          end
        end
        ST_ADDR: begin
          addr_d    = addr_in[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (cmd_q == CMD_READ) begin
              state_d = ST_RD_OUT;
              tx_d    = mem[a_lo];
              ptr_d   = a_lo + ONE;
            end else begin
              state_d = ST_PP_IN;
              ptr_d   = a_lo;
            end
          end
        end
        ST_PP_IN: begin
          sh_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            ptr_d     = ptr_q + ONE;
            // NOR programming can only clear bits
            if (wel_q && wpn_s && !wip_q) begin
              mem_we = 1'b1;
              mem_wa = ptr_q;
              mem_wd = mem[ptr_q] & byte_in;
            end
          end
        end
        default: ;
      endcase
    end else if (sck_fall && state_q == ST_RD_OUT) begin
      sdo_d     = tx_q[7];
      tx_d      = {tx_q[6:0], 1'b0};
      out_cnt_d = out_cnt_q + 3'd1;
      // last bit of the byte is out: preload the next byte
      if (out_cnt_q == 3'd7) begin
        case (cmd_q)
          CMD_RDID: begin
            case (id_idx_q)
              2'd1:    tx_d = JEDEC_ID[15:8];
              2'd2:    tx_d = JEDEC_ID[7:0];
              default: tx_d = 8'h00;
            endcase
            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
          end
          CMD_RDSR: tx_d = status_byte(wel_q, wip_q);
          CMD_READ: begin
            tx_d  = mem[ptr_q];
            ptr_d = ptr_q + ONE;
          end
          default: tx_d = 8'h00;
        endcase
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      cmd_q     <= CMD_NONE;
      addr_q    <= '0;
      ptr_q     <= '0;
      tx_q      <= '0;
      out_cnt_q <= '0;
      id_idx_q  <= '0;
      wel_q     <= 1'b0;
      wip_q     <= 1'b0;
      er_ptr_q  <= '0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      tx_q      <= tx_d;
      out_cnt_q <= out_cnt_d;
      id_idx_q  <= id_idx_d;
      wel_q     <= wel_d;
      wip_q     <= wip_d;
      er_ptr_q  <= er_ptr_d;
      sdo_q     <= sdo_d;
    end
  end

  // single write port shared by erase and page program; contents not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign bus.sdo_dq1 = sdo_q;
  assign bus.busy    = wip_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard-driven bench for spi_flash_responder: expected bytes are queued
// as commands are issued and popped as bytes are shifted back out.
module tb_spi_flash_responder;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [7:0] exp_q [$];

  spi_flash_responder_if bus ();

  spi_flash_responder #(.MEM_DEPTH(256), .JEDEC_ID(24'hEF4018)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one mode-0 byte: sample sdo just before each rise, 16 clk per sck period
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.sdi_dq0 = tx[i];
      wait_clk(8);
      rx[i] = bus.sdo_dq1;
      bus.sck = 1'b1;
      wait_clk(8);
      bus.sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    bus.csn = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_hi();
    wait_clk(4);
    bus.csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic simple_cmd(input logic [7:0] c);
    logic [7:0] rx;
    cs_lo();
    xfer(c, rx);
    cs_hi();
  endtask

  task automatic cmd_addr(input logic [7:0] c, input logic [23:0] a);
    logic [7:0] rx;
    xfer(c, rx);
    xfer(a[23:16], rx);
    xfer(a[15:8], rx);
    xfer(a[7:0], rx);
  endtask

  task automatic test_reset();
    wait_clk(3);
    vectors++;
    if (bus.sdo_dq1 !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in: sdo=%b busy=%b expected 0/0", bus.sdo_dq1, bus.busy);
    end
    rst = 1'b0;
    wait_clk(4);
    vectors++;
    if (bus.sdo_dq1 !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: sdo=%b busy=%b expected 0/0", bus.sdo_dq1, bus.busy);
    end
  endtask

  task automatic test_rdid();
    logic [7:0] rx, e;
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
    exp_q.push_back(8'h18); exp_q.push_back(8'h00);
    cs_lo();
    xfer(8'h9F, rx);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, rx);
      e = exp_q.pop_front();
      vectors++;
      if (rx !== e) begin
        miscompares++;
        $display("FAIL rdid[%0d]: got %h expected %h", i, rx, e);
      end
    end
    cs_hi();
  endtask

  // RDSR one byte, compared against the queue head
  task automatic test_status(input string name, input logic [7:0] want);
    logic [7:0] rx, e;
    exp_q.push_back(want);
    cs_lo();
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    cs_hi();
    e = exp_q.pop_front();
    vectors++;
    if (rx !== e) begin
      miscompares++;
      $display("FAIL %s: status got %h expected %h", name, rx, e);
    end
  endtask

  task automatic test_wel();
    simple_cmd(8'h06);
    test_status("wren_status", 8'h02);
    simple_cmd(8'h04);
    test_status("wrdi_status", 8'h00);
  endtask

  task automatic test_read(input string name, input logic [23:0] a, input int n);
    logic [7:0] rx, e;
    cs_lo();
    cmd_addr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      e = exp_q.pop_front();
      vectors++;
      if (rx !== e) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, rx, e);
      end
    end
    cs_hi();
  endtask

  task automatic test_erase();
    logic [7:0] rx, e;
    int busy_cnt;
    busy_cnt = 0;
    simple_cmd(8'h06);
    cs_lo();
    xfer(8'hC7, rx);
    wait_clk(4);
    bus.csn = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (bus.busy === 1'b1) busy_cnt++;
        end
      end
      begin
        wait_clk(6);
        exp_q.push_back(8'h01);
        cs_lo();
        xfer(8'h05, rx);
        xfer(8'h00, rx);
        cs_hi();
        e = exp_q.pop_front();
        vectors++;
        if (rx !== e) begin
          miscompares++;
          $display("FAIL erase_wip_status: got %h expected %h", rx, e);
        end
      end
    join
    vectors++;
    if (busy_cnt != 256) begin
      miscompares++;
      $display("FAIL erase_busy_len: got %0d expected 256", busy_cnt);
    end
    test_status("erase_done_status", 8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    test_read("erase_wrap_read", 24'h0000FE, 4);
  endtask

  task automatic test_pp();
    logic [7:0] rx;
    simple_cmd(8'h06);
    cs_lo();
    cmd_addr(8'h02, 24'h000010);
    xfer(8'h5A, rx);
    xfer(8'hF0, rx);
    cs_hi();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hF0);
    test_read("pp_read", 24'h000010, 2);
    // no WREN: program is discarded
    cs_lo();
    cmd_addr(8'h02, 24'h000010);
    xfer(8'h0F, rx);
    xfer(8'h0F, rx);
    cs_hi();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hF0);
    test_read("pp_nowel_read", 24'h000010, 2);
    // upper address bits ignored: 0xAB0010 aliases 0x10
    exp_q.push_back(8'h5A);
    test_read("addr_alias_read", 24'hAB0010, 1);
  endtask

  task automatic test_wp();
    logic [7:0] rx;
    bus.wpn_dq2 = 1'b0;
    wait_clk(4);
    simple_cmd(8'h06);
    cs_lo();
    cmd_addr(8'h02, 24'h000020);
    xfer(8'h00, rx);
    cs_hi();
    bus.wpn_dq2 = 1'b1;
    wait_clk(4);
    exp_q.push_back(8'hFF);
    test_read("wp_read", 24'h000020, 1);
    test_status("wp_wel_cleared", 8'h00);
  endtask

  task automatic test_partial();
    logic [7:0] c;
    c = 8'h06;
    cs_lo();
    for (int i = 7; i >= 3; i--) begin
      bus.sdi_dq0 = c[i];
      wait_clk(8);
      bus.sck = 1'b1;
      wait_clk(8);
      bus.sck = 1'b0;
    end
    cs_hi();
    test_status("partial_wren", 8'h00);
  endtask

  task automatic test_rst_mid();
    logic [7:0] rx, e;
    exp_q.push_back(8'h5A);
    cs_lo();
    cmd_addr(8'h03, 24'h000010);
    xfer(8'h00, rx);
    e = exp_q.pop_front();
    vectors++;
    if (rx !== e) begin
      miscompares++;
      $display("FAIL rst_pre_read: got %h expected %h", rx, e);
    end
    wait_clk(5);
    vectors++;
    if (bus.sdo_dq1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_sdo: got %b expected 1", bus.sdo_dq1);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.sdo_dq1 !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_read: sdo=%b busy=%b expected 0/0", bus.sdo_dq1, bus.busy);
    end
    bus.csn = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    // abort an erase in flight
    simple_cmd(8'h06);
    simple_cmd(8'hC7);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL erase2_busy: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_erase: busy got %b expected 0", bus.busy);
    end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    test_status("post_rst_status", 8'h00);
  endtask

  initial begin
    rst          = 1'b1;
    bus.csn      = 1'b1;
    bus.sck      = 1'b0;
    bus.sdi_dq0  = 1'b0;
    bus.wpn_dq2  = 1'b1;
    bus.hldn_dq3 = 1'b1;
    test_reset();
    test_rdid();
    test_wel();
    test_erase();
    test_pp();
    test_wp();
    test_partial();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
